// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller. Issues one memory operation per clock to the
// memory under test, leads each write with its data by one clock, and checks
// read data returned two clocks after the read command.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 15,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);
  localparam logic [DATA_WIDTH-1:0] D0    = '0;
  localparam logic [DATA_WIDTH-1:0] D1    = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One March operation: element, address and position within the element
  // (sub=0 is the read of a read/write pair, sub=1 the write).
  typedef struct packed {
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sub;
  } op_t;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic op_is_write(input op_t op);
    logic w;
    if (op.elem == 3'd0)      w = 1'b1;
    else if (op.elem == 3'd5) w = 1'b0;
    else                      w = op.sub;
    return w;
  endfunction

  function automatic logic op_last_sub(input op_t op);
    return (op.elem == 3'd0) || (op.elem == 3'd5) || op.sub;
  endfunction

  // Write data: w1 occurs in M1 and M3, every other write is w0.
  function automatic logic [DATA_WIDTH-1:0] elem_wdata(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? D1 : D0;
  endfunction

  // Read expectation: r1 occurs in M2 and M4, every other read is r0.
  function automatic logic [DATA_WIDTH-1:0] elem_expect(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? D1 : D0;
  endfunction

  function automatic logic op_final(input op_t op);
    return (op.elem == 3'd5) && (op.addr == CAP_A);
  endfunction

  // Successor of a non-final operation; addresses stop at CAPACITY or 0 and
  // the next element begins at its own starting address.
  function automatic op_t op_succ(input op_t op);
    op_t nx;
    nx = op;
    if (!op_last_sub(op)) begin
      nx.sub = 1'b1;
    end else begin
      nx.sub = 1'b0;
      if (elem_down(op.elem) ? (op.addr != '0) : (op.addr != CAP_A)) begin
        nx.addr = elem_down(op.elem) ? (op.addr - 1'b1) : (op.addr + 1'b1);
      end else begin
        nx.elem = op.elem + 3'd1;
        nx.addr = elem_down(nx.elem) ? CAP_A : '0;
      end
    end
    return nx;
  endfunction

  state_e                state_q, state_d;
  op_t                   gen_q, gen_d;
  logic                  gen_end_q, gen_end_d;
  logic                  drain_q, drain_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            cur_elem_q, cur_elem_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  p1_vld_q, p1_vld_d, p2_vld_q;
  logic [DATA_WIDTH-1:0] p1_exp_q, p1_exp_d, p2_exp_q;
  logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d, p2_addr_q;
  logic [2:0]            p1_elem_q, p1_elem_d, p2_elem_q;

  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;

  logic                  launch;
  op_t                   gen_nxt;
  logic [DATA_WIDTH-1:0] syndrome;

  assign launch  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign gen_nxt = op_succ(gen_q);

  // Sequencer: next state, operation generator and memory command outputs.
  // The generator runs one operation ahead of the presented command so the
  // write data for the following operation can be driven a clock early.
  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    gen_end_d  = gen_end_q;
    drain_d    = drain_q;
    wr_d       = 1'b0;
    addr_d     = '0;
    cur_elem_d = cur_elem_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_PREP;
          gen_d     = '0;
          gen_end_d = 1'b0;
          wdata_d   = elem_wdata(3'd0);
        end
      end
      ST_PREP, ST_RUN: begin
        if ((state_q == ST_RUN) && gen_end_q) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d    = ST_RUN;
          wr_d       = op_is_write(gen_q);
          addr_d     = gen_q.addr;
          cur_elem_d = gen_q.elem;
          if (op_final(gen_q)) begin
            gen_end_d = 1'b1;
          end else begin
            gen_d = gen_nxt;
            if (op_is_write(gen_nxt)) wdata_d = elem_wdata(gen_nxt.elem);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gen_q      <= '0;
      gen_end_q  <= 1'b0;
      drain_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cur_elem_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      gen_end_q  <= gen_end_d;
      drain_q    <= drain_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      cur_elem_q <= cur_elem_d;
      wdata_q    <= wdata_d;
    end
  end

  assign syndrome = rdata ^ p2_exp_q;

  // Compare path: tag each issued read, then check rdata when its tag
  // reaches the second stage; launching a test clears the previous results.
  always_comb begin
    p1_vld_d    = (state_q == ST_RUN) && !wr_q;
    p1_exp_d    = elem_expect(cur_elem_q);
    p1_addr_d   = addr_q;
    p1_elem_d   = cur_elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_syn_d  = fail_syn_q;
    fail_cnt_d  = fail_cnt_q;
    if (p2_vld_q && (syndrome != '0)) begin
      fail_d = 1'b1;
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
      if (!fail_q) begin
        fail_addr_d = p2_addr_q;
        fail_elem_d = p2_elem_q;
        fail_syn_d  = syndrome;
      end
    end
    if (launch) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_syn_d  = '0;
      fail_cnt_d  = '0;
    end
  end

  // Compare pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld_q    <= 1'b0;
      p1_exp_q    <= '0;
      p1_addr_q   <= '0;
      p1_elem_q   <= '0;
      p2_vld_q    <= 1'b0;
      p2_exp_q    <= '0;
      p2_addr_q   <= '0;
      p2_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_syn_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      p1_vld_q    <= p1_vld_d;
      p1_exp_q    <= p1_exp_d;
      p1_addr_q   <= p1_addr_d;
      p1_elem_q   <= p1_elem_d;
      p2_vld_q    <= p1_vld_q;
      p2_exp_q    <= p1_exp_q;
      p2_addr_q   <= p1_addr_q;
      p2_elem_q   <= p1_elem_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_syn_q  <= fail_syn_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign write_read    = wr_q;
  assign address       = addr_q;
  assign wdata         = wdata_q;
  assign busy          = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_element  = fail_elem_q;
  assign fail_syndrome = fail_syn_q;
  assign fail_count    = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a fault-injecting memory with write-data
// register and 2-clock read latency, plus an abstract March C- model.
module tb_mbist_march_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int CAP  = 15;
  localparam int CW   = 8;
  localparam int N    = CAP + 1;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [DW-1:0] fail_syndrome;
  logic [CW-1:0] fail_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mbist_march_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CAPACITY  (CAP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .write_read   (write_read),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element),
    .fail_syndrome(fail_syndrome),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  // Fault configuration: 0 none, 1 stuck-at cell bit, 2 coupling at address 7.
  int unsigned fault_kind = 0;
  int unsigned fault_addr = 0;
  int unsigned fault_bit  = 0;
  logic        fault_val  = 1'b0;

  function automatic logic [DW-1:0] fault_store(input int unsigned a, input logic [DW-1:0] nv,
                                                input logic [DW-1:0] m6, input logic [DW-1:0] m7,
                                                input logic [DW-1:0] m8);
    logic [DW-1:0] r;
    r = nv;
    if (fault_kind == 1 && a == fault_addr) r[fault_bit] = fault_val;
    if (fault_kind == 2 && a == 7 && m8[5] && !m6[5] && !m7[6] && !m7[4]) r[5] = m7[5];
    return r;
  endfunction

  // Memory under test: registers wdata, writes the registered value, 2-clock reads.
  logic [DW-1:0] mem [N] = '{default: '0};
  logic [DW-1:0] mem_wreg;
  logic [DW-1:0] rd1;
  always @(posedge clk) begin
    mem_wreg <= wdata;
    if (write_read) mem[address] <= fault_store(int'(address), mem_wreg, mem[6], mem[7], mem[8]);
    rd1   <= mem[address];
    rdata <= rd1;
  end

  // Abstract March C- operation list.
  logic          exp_wr   [NOPS];
  int unsigned   exp_addr [NOPS];
  logic [DW-1:0] exp_data [NOPS];
  int unsigned   exp_elem [NOPS];

  task automatic build_ops();
    int unsigned k;
    k = 0;
    for (int unsigned e = 0; e < 6; e++) begin
      for (int unsigned i = 0; i < N; i++) begin
        int unsigned a;
        a = (e == 3 || e == 4) ? (N - 1 - i) : i;
        if (e != 0) begin
          exp_wr[k] = 1'b0; exp_addr[k] = a; exp_elem[k] = e;
          exp_data[k] = (e == 2 || e == 4) ? '1 : '0;
          k++;
        end
        if (e != 5) begin
          exp_wr[k] = 1'b1; exp_addr[k] = a; exp_elem[k] = e;
          exp_data[k] = (e == 1 || e == 3) ? '1 : '0;
          k++;
        end
      end
    end
  endtask

  logic          m_fail;
  int unsigned   m_addr, m_elem, m_cnt;
  logic [DW-1:0] m_syn;

  // Predicted results: replay the operation list on a copy of the memory.
  task automatic compute_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] rv;
    for (int i = 0; i < N; i++) m[i] = mem[i];
    m_fail = 1'b0; m_addr = 0; m_elem = 0; m_cnt = 0; m_syn = '0;
    for (int k = 0; k < NOPS; k++) begin
      if (exp_wr[k]) begin
        m[exp_addr[k]] = fault_store(exp_addr[k], exp_data[k], m[6], m[7], m[8]);
      end else begin
        rv = m[exp_addr[k]];
        if (rv != exp_data[k]) begin
          if (!m_fail) begin
            m_addr = exp_addr[k]; m_elem = exp_elem[k]; m_syn = rv ^ exp_data[k];
          end
          m_fail = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr"}, write_read, 0);
    check({tag, "_addr"}, address, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_faddr"}, fail_addr, 0);
    check({tag, "_felem"}, fail_element, 0);
    check({tag, "_fsyn"}, fail_syndrome, 0);
    check({tag, "_fcnt"}, fail_count, 0);
  endtask

  // Full run from a start pulse, checked every cycle until done.
  task automatic run_test(input bit spurious, input string tag);
    logic [DW-1:0] exp_wd;
    compute_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_prep_busy"}, busy, 1);
    check({tag, "_prep_done"}, done, 0);
    check({tag, "_prep_wr"}, write_read, 0);
    check({tag, "_prep_wdata"}, wdata, 0);
    check({tag, "_prep_fail"}, fail, 0);
    check({tag, "_prep_fcnt"}, fail_count, 0);
    exp_wd = '0;
    for (int t = 1; t <= NOPS + 3; t++) begin
      start = spurious && (t <= 150) && ($urandom_range(0, 7) == 0);
      tick();
      start = 1'b0;
      if (t <= NOPS) begin
        check($sformatf("%s_wr_t%0d", tag, t), write_read, exp_wr[t-1]);
        check($sformatf("%s_addr_t%0d", tag, t), address, exp_addr[t-1]);
        if (t < NOPS && exp_wr[t]) exp_wd = exp_data[t];
        check($sformatf("%s_wdata_t%0d", tag, t), wdata, exp_wd);
        if (exp_wr[t-1]) check($sformatf("%s_memwreg_t%0d", tag, t), mem_wreg, exp_data[t-1]);
      end else if (t <= NOPS + 2) begin
        check($sformatf("%s_drain_wr_t%0d", tag, t), write_read, 0);
      end
      if (t <= NOPS + 2) begin
        check($sformatf("%s_busy_t%0d", tag, t), busy, 1);
        check($sformatf("%s_done_t%0d", tag, t), done, 0);
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_wr"}, write_read, 0);
    check({tag, "_done_addr"}, address, 0);
    check({tag, "_fail"}, fail, m_fail);
    check({tag, "_fcnt"}, fail_count, m_cnt);
    check({tag, "_faddr"}, fail_addr, m_addr);
    check({tag, "_felem"}, fail_element, m_elem);
    check({tag, "_fsyn"}, fail_syndrome, m_syn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_ops();
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_reset_vals("idle");

    fault_kind = 0;
    run_test(1'b0, "clean");

    fault_kind = 1; fault_addr = 7; fault_bit = 5; fault_val = 1'b0;
    run_test(1'b0, "sa0");
    check("sa0_lit_fail", fail, 1);
    check("sa0_lit_addr", fail_addr, 7);
    check("sa0_lit_elem", fail_element, 2);
    check("sa0_lit_syn", fail_syndrome, 8'h20);
    check("sa0_lit_cnt", fail_count, 2);

    fault_kind = 0;
    run_test(1'b1, "clear");

    fault_kind = 2;
    run_test(1'b0, "coup");
    check("coup_lit_fail", fail, 1);
    check("coup_lit_addr", fail_addr, 7);
    check("coup_lit_cnt_ge1", (fail_count >= 1), 1);
    check("coup_lit_elem", fail_element, 4);
    check("coup_lit_syn", fail_syndrome, 8'h20);

    fault_kind = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("postrst");
    run_test(1'b0, "fresh");

    for (int r = 0; r < 5; r++) begin
      fault_kind = 1;
      fault_addr = $urandom_range(0, CAP);
      fault_bit  = $urandom_range(0, DW - 1);
      fault_val  = 1'($urandom_range(0, 1));
      run_test(1'b1, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
